// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) arbiter for a single-port synchronous memory.
// Each transfer is IDLE -> ACC -> RESP; CPU has priority, bounded by a DMA starvation limit.
module mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int DMA_LIM = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises req (with we/addr/wdata valid) and holds it until
  // its one-cycle done pulse; a req still high in the following IDLE is a new request.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(DMA_LIM);

  state_t              state_q, state_d;
  logic                owner_q;    // 0 = CPU, 1 = DMA
  logic                lat_we_q;
  logic [ADDR_W-1:0]   lat_addr_q;
  logic [DATA_W-1:0]   lat_wdata_q;
  logic [3:0]          starve_q;
  logic [DATA_W-1:0]   cpu_rdata_q, dma_rdata_q;
  logic                starve_full;
  logic                cpu_win, dma_win;

  assign starve_full = (starve_q == STARVE_MAX);

  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        cpu_win = cpu_req && !(dma_req && starve_full);
        dma_win = dma_req && !cpu_win;
        if (cpu_win || dma_win) state_d = ACC;
      end
      ACC:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q     <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      starve_q    <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (cpu_win) begin
        owner_q     <= 1'b0;
        lat_we_q    <= cpu_we;
        lat_addr_q  <= cpu_addr;
        lat_wdata_q <= cpu_wdata;
      end else if (dma_win) begin
        owner_q     <= 1'b1;
        lat_we_q    <= dma_we;
        lat_addr_q  <= dma_addr;
        lat_wdata_q <= dma_wdata;
      end
      // Starvation only counts CPU wins that actually kept a waiting DMA out.
      if (state_q == IDLE) begin
        if (dma_win || !dma_req) starve_q <= '0;
        else if (cpu_win && !starve_full) starve_q <= starve_q + 4'd1;
      end
      // Memory read data is valid during RESP; capture it on the way back to IDLE.
      if (state_q == RESP && !lat_we_q) begin
        if (owner_q) dma_rdata_q <= mem_rdata;
        else         cpu_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_en    = (state_q == ACC);
  assign mem_we    = (state_q == ACC) && lat_we_q;
  assign mem_addr  = lat_addr_q;
  assign mem_wdata = lat_wdata_q;

  assign cpu_gnt   = (state_q != IDLE) && !owner_q;
  assign dma_gnt   = (state_q != IDLE) &&  owner_q;
  assign cpu_done  = (state_q == RESP) && !owner_q;
  assign dma_done  = (state_q == RESP) &&  owner_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous memory model.
module tb_mem_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [ADDR_W-1:0] cpu_addr, dma_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata;
  logic              cpu_gnt, cpu_done, dma_gnt, dma_done;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [1:0]        dbg_state;

  logic [DATA_W-1:0] mem [0:4095];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DMA_LIM(3)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cpu_gnt, cpu_done, dma_gnt, dma_done, mem_en, mem_we} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {cpu_gnt, cpu_done, dma_gnt, dma_done, mem_en, mem_we});
    else passed++;
    checks++;
    if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== '0)
      $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, cpu_rdata, dma_rdata});
    else passed++;
    checks++;
    if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else passed++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_en, dbg_state} !== 3'b0) $display("FAIL post_reset_idle: got %b want 000", {mem_en, dbg_state});
    else passed++;
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h005;
    @(negedge clk);
    checks++;
    if ({dbg_state, mem_en, mem_we, cpu_gnt, dma_gnt, cpu_done} !== 7'b01_10100)
      $display("FAIL cpu_read_acc: got %b want 0110100", {dbg_state, mem_en, mem_we, cpu_gnt, dma_gnt, cpu_done});
    else passed++;
    checks++;
    if (mem_addr !== 12'h005) $display("FAIL cpu_read_addr: got %h want 005", mem_addr); else passed++;
    @(negedge clk);
    checks++;
    if ({cpu_done, cpu_gnt, mem_en} !== 3'b110) $display("FAIL cpu_read_done: got %b want 110", {cpu_done, cpu_gnt, mem_en});
    else passed++;
    cpu_req = 0;
    @(negedge clk);
    checks++;
    if ({cpu_done, cpu_gnt} !== 2'b00) $display("FAIL cpu_read_end: got %b want 00", {cpu_done, cpu_gnt}); else passed++;
    checks++;
    if (cpu_rdata !== 16'h1234) $display("FAIL cpu_read_data: got %h want 1234", cpu_rdata); else passed++;
  endtask

  task automatic test_dma_write();
    dma_req = 1; dma_we = 1; dma_addr = 12'hFFF; dma_wdata = 16'hBEEF;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, dma_gnt, cpu_gnt} !== 4'b1110) $display("FAIL dma_wr_acc: got %b want 1110", {mem_en, mem_we, dma_gnt, cpu_gnt});
    else passed++;
    checks++;
    if ({mem_addr, mem_wdata} !== {12'hFFF, 16'hBEEF}) $display("FAIL dma_wr_bus: got %h/%h want FFF/BEEF", mem_addr, mem_wdata);
    else passed++;
    @(negedge clk);
    checks++;
    if ({dma_done, cpu_done} !== 2'b10) $display("FAIL dma_wr_done: got %b want 10", {dma_done, cpu_done}); else passed++;
    dma_req = 0; dma_we = 0;
    @(negedge clk);
    checks++;
    if (dma_done !== 1'b0) $display("FAIL dma_wr_pulse: got %b want 0", dma_done); else passed++;
    checks++;
    if (dma_rdata !== 16'h0000) $display("FAIL dma_wr_rdata: got %h want 0000", dma_rdata); else passed++;
    checks++;
    if (mem[12'hFFF] !== 16'hBEEF) $display("FAIL dma_wr_mem: got %h want BEEF", mem[12'hFFF]); else passed++;
    checks++;
    if (cpu_rdata !== 16'h1234) $display("FAIL cpu_rdata_held: got %h want 1234", cpu_rdata); else passed++;
  endtask

  task automatic test_fairness();
    logic order [8];
    logic exp_order [8];
    int   n = 0;
    int   overlaps = 0;
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h005;
    dma_req = 1; dma_we = 0; dma_addr = 12'hFFF;
    for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
      @(negedge clk);
      if (cpu_gnt && dma_gnt) overlaps++;
      if (cpu_done || dma_done) begin
        order[n] = dma_done;
        n++;
      end
    end
    cpu_req = 0; dma_req = 0;
    checks++;
    if (n !== 8) $display("FAIL fair_count: got %0d want 8", n); else passed++;
    checks++;
    if (overlaps !== 0) $display("FAIL fair_overlap: got %0d want 0", overlaps); else passed++;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (order[i] !== exp_order[i]) $display("FAIL fair_order[%0d]: got %b want %b", i, order[i], exp_order[i]);
      else passed++;
    end
    checks++;
    if (dma_rdata !== 16'hBEEF) $display("FAIL fair_dma_rdata: got %h want BEEF", dma_rdata); else passed++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int stray_done = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h005;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1) $display("FAIL rst_mid_acc: got %b want 1", mem_en); else passed++;
    reset = 1'b0;
    #1;
    checks++;
    if ({cpu_gnt, cpu_done, mem_en, mem_we, dbg_state} !== 6'b0)
      $display("FAIL rst_mid_outs: got %b want 000000", {cpu_gnt, cpu_done, mem_en, mem_we, dbg_state});
    else passed++;
    checks++;
    if ({cpu_rdata, dma_rdata, mem_addr} !== '0) $display("FAIL rst_mid_data: got %h want 0", {cpu_rdata, dma_rdata, mem_addr});
    else passed++;
    cpu_req = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_done) stray_done++;
    end
    checks++;
    if (stray_done !== 0) $display("FAIL rst_mid_nodone: got %0d want 0", stray_done); else passed++;
    reset = 1'b1;
    cpu_req = 1;
    @(negedge clk);
    checks++;
    if ({dbg_state, cpu_gnt} !== 3'b011) $display("FAIL rst_first_arb: got %b want 011", {dbg_state, cpu_gnt}); else passed++;
    @(negedge clk);
    cpu_req = 0;
    @(negedge clk);
    checks++;
    if (cpu_rdata !== 16'h1234) $display("FAIL rst_recover_data: got %h want 1234", cpu_rdata); else passed++;
  endtask

  task automatic test_addr_latch();
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
    @(negedge clk);
    cpu_addr = 12'h020;
    #1;
    checks++;
    if (mem_addr !== 12'h010) $display("FAIL latch_addr: got %h want 010", mem_addr); else passed++;
    @(negedge clk);
    cpu_req = 0;
    @(negedge clk);
    checks++;
    if (cpu_rdata !== 16'hA5A5) $display("FAIL latch_data: got %h want A5A5", cpu_rdata); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h005] = 16'h1234;
    mem[12'h010] = 16'hA5A5;
    mem[12'h020] = 16'h5A5A;
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_fairness();
    test_reset_mid();
    test_addr_latch();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 12, memory address width.
REQ-002 Parameter DATA_W, 16, memory word width.
REQ-003 Parameter DMA_LIM, 3, consecutive CPU grants allowed while DMA waits (1..15).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cpu_req  input  1  CPU transfer request, level, held until cpu_done.
REQ-007 cpu_we  input  1  CPU write (1) / read (0); valid while cpu_req high.
REQ-008 cpu_addr  input  ADDR_W  CPU address.
REQ-009 cpu_wdata  input  DATA_W  CPU write data.
REQ-010 cpu_gnt  output  1  CPU owns memory this cycle.
REQ-011 cpu_done  output  1  one-cycle CPU completion pulse.
REQ-012 cpu_rdata  output  DATA_W  registered CPU read data.
REQ-013 dma_req, dma_we, dma_addr, dma_wdata  input  1/1/ADDR_W/DATA_W  DMA requester, same rules as CPU.
REQ-014 dma_gnt, dma_done, dma_rdata  output  1/1/DATA_W  DMA equivalents of CPU outputs.
REQ-015 mem_en  output  1  memory access strobe.
REQ-016 mem_we  output  1  memory write enable, valid with mem_en.
REQ-017 mem_addr  output  ADDR_W  memory address.
REQ-018 mem_wdata  output  DATA_W  memory write data.
REQ-019 mem_rdata  input  DATA_W  synchronous memory read data, valid one cycle after mem_en.

Function
REQ-020 FSM states SHALL be IDLE, ACC, RESP; transitions IDLE->ACC on any grant, ACC->RESP always, RESP->IDLE always.
REQ-021 In IDLE, arbitration SHALL sample cpu_req/dma_req; only one winner; no request -> stay IDLE.
REQ-022 CPU SHALL win when both request unless starve count equals DMA_LIM, in which case DMA wins.
REQ-023 Starve count SHALL increment on each CPU grant made while dma_req high, clear on DMA grant or when dma_req low in IDLE, and saturate at DMA_LIM.
REQ-024 On grant, winner's we/addr/wdata SHALL be latched; later input changes do not affect the transfer.
REQ-025 In ACC, mem_en=1 and mem_we/mem_addr/mem_wdata SHALL drive latched values; in IDLE and RESP mem_en=0, mem_we=0.
REQ-026 Owner's gnt SHALL be high in ACC and RESP, low in IDLE; both gnt never high together.
REQ-027 In RESP, owner's done SHALL be high exactly one cycle; on a read, owner's rdata register SHALL load mem_rdata at the RESP->IDLE edge... held until the next read by that requester.
REQ-028 Writes SHALL NOT modify rdata.
REQ-029 Latency: req sampled high in IDLE at edge N -> ACC at N+1, done in cycle N+1..N+2 (RESP), IDLE at N+3; max throughput one transfer per 3 cycles.
REQ-030 A requester keeping req high in the IDLE following its done SHALL be treated as a new request.
REQ-031 Requests arriving during ACC/RESP SHALL wait for the next IDLE; no request is lost while held high.

Reset
REQ-032 reset low SHALL asynchronously force IDLE, all gnt/done/mem_en/mem_we low, mem_addr/mem_wdata 0, both rdata 0, starve count 0.
REQ-033 Reset during ACC or RESP SHALL abort the transfer with no done pulse; a write in ACC may or may not reach memory.
REQ-034 First arbitration SHALL occur at the first rising edge after reset goes high.

Verification
REQ-035 Reset low, all inputs 0 -> all outputs 0, FSM IDLE; release -> still idle, mem_en 0.
REQ-036 CPU read addr 0x005, memory word 0x1234 -> mem_en one cycle with addr 0x005, cpu_done one cycle, cpu_rdata 0x1234, done 2 cycles after grant edge.
REQ-037 DMA write addr 0xFFF data 0xBEEF, CPU idle -> mem_en=mem_we=1, addr 0xFFF, wdata 0xBEEF, dma_done one pulse, dma_rdata unchanged.
REQ-038 CPU and DMA both held high continuously, DMA_LIM=3 -> grant order CPU,CPU,CPU,DMA repeating; gnt never overlap.
REQ-039 Reset asserted in ACC of CPU read -> outputs 0 immediately, no cpu_done, next transfer after release completes normally.
REQ-040 cpu_addr changed during ACC -> mem_addr keeps latched value for the transfer.
